// File: rtl/psum_pkg.sv
// Shared constants, types and lane helpers for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned NUM_LANES  = 36;
  localparam int unsigned PSUM_W     = 24;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned PSUM_BUS_W = NUM_LANES * PSUM_W;
  localparam int unsigned OUT_BUS_W  = NUM_LANES * OUT_W;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef logic [PSUM_BUS_W-1:0] psum_bus_t;
  typedef logic [OUT_BUS_W-1:0]  out_bus_t;

  function automatic logic signed [PSUM_W-1:0] psum_lane(input psum_bus_t bus,
                                                         input int unsigned idx);
    return $signed(bus[idx*PSUM_W +: PSUM_W]);
  endfunction

  function automatic out_bus_t out_set_lane(input out_bus_t bus, input int unsigned idx,
                                            input logic [OUT_W-1:0] val);
    out_bus_t r;
    r = bus;
    r[idx*OUT_W +: OUT_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Psum input stream and valid/ready result stream of the accumulator.
interface psum_accum_if;
  import psum_pkg::*;

  logic      Psum_valid;
  psum_bus_t Psum;
  logic      out_valid;
  logic      out_ready;
  out_bus_t  out_data;

  modport master (output Psum_valid, Psum, out_ready, input out_valid, out_data);
  modport slave  (input Psum_valid, Psum, out_ready, output out_valid, out_data);
endinterface

// File: rtl/psum_quant.sv
// Per-lane round-half-up shift, optional ReLU and int8 saturation (combinational).
module psum_quant import psum_pkg::*; (
  input  logic signed [ACC_W-1:0]   sum,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   res_c
);

  localparam int unsigned RW = ACC_W + 1;

  logic signed [RW-1:0] wide_c;
  logic signed [RW-1:0] bias_c;
  logic signed [RW-1:0] r_c;

  // One guard bit keeps the rounding bias from wrapping at large shifts.
  always_comb begin
    wide_c = RW'(sum);
    bias_c = '0;
    if (shift != '0) begin
      bias_c = RW'(1) <<< (shift - SHIFT_W'(1));
    end
    r_c = (wide_c + bias_c) >>> shift;
    if (relu && r_c[RW-1]) begin
      r_c = '0;
    end
    if (r_c > RW'(OUT_MAX)) begin
      res_c = OUT_W'(OUT_MAX);
    end else if (r_c < RW'(OUT_MIN)) begin
      res_c = OUT_W'(OUT_MIN);
    end else begin
      res_c = r_c[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Accumulates Psum beats per output group, quantizes to int8 and buffers results in a 2-entry FIFO.
module psum_accum import psum_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic [RND_W-1:0]   cfg_rounds,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu,
  psum_accum_if.slave        bus,
  output logic [RND_W-1:0]   round_cnt,
  output logic               busy,
  output logic               ovf_err
);

  state_e               state_q, state_d;
  logic [RND_W-1:0]     round_cnt_q, round_cnt_d;
  logic [RND_W-1:0]     rounds_q, rounds_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q [NUM_LANES];
  logic signed [ACC_W-1:0] acc_d [NUM_LANES];

  out_bus_t             mem_q [FIFO_DEPTH];
  out_bus_t             mem_d [FIFO_DEPTH];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  out_bus_t             out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  logic                 first_beat;
  logic                 cfg_load;
  logic [RND_W-1:0]     eff_rounds;
  logic [SHIFT_W-1:0]   eff_shift;
  logic                 eff_relu;
  logic                 final_beat;
  logic signed [ACC_W-1:0] sum_c [NUM_LANES];
  logic signed [OUT_W-1:0] q_c   [NUM_LANES];
  out_bus_t             result;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.Psum_valid && !final_beat) state_d = ST_ACCUM;
      ST_ACCUM: if (bus.Psum_valid && final_beat)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    first_beat = 1'b0;
    cfg_load   = 1'b0;
    if (state_q == ST_IDLE) begin
      first_beat = 1'b1;
      cfg_load   = bus.Psum_valid;
    end
  end

  // The first beat of a group uses live config; later beats use the latched copy.
  always_comb begin
    eff_rounds = rounds_q;
    eff_shift  = shift_q;
    eff_relu   = relu_q;
    if (first_beat) begin
      eff_rounds = (cfg_rounds == '0) ? RND_W'(1) : cfg_rounds;
      eff_shift  = cfg_shift;
      eff_relu   = cfg_relu;
    end
    final_beat = bus.Psum_valid &&
                 ((RND_W+1)'(round_cnt_q) + (RND_W+1)'(1) == (RND_W+1)'(eff_rounds));
    rounds_d    = cfg_load ? eff_rounds : rounds_q;
    shift_d     = cfg_load ? eff_shift  : shift_q;
    relu_d      = cfg_load ? eff_relu   : relu_q;
    round_cnt_d = round_cnt_q;
    if (bus.Psum_valid) begin
      round_cnt_d = final_beat ? '0 : round_cnt_q + RND_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_c[i] = (first_beat ? ACC_W'(0) : acc_q[i]) + ACC_W'(psum_lane(bus.Psum, i));
      acc_d[i] = acc_q[i];
      if (bus.Psum_valid && !final_beat) acc_d[i] = sum_c[i];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    psum_quant u_quant (
      .sum   (sum_c[g]),
      .shift (eff_shift),
      .relu  (eff_relu),
      .res_c (q_c[g])
    );
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      result = out_set_lane(result, i, q_c[i]);
    end
  end

  // A pop in the same cycle frees the slot that a push to a full FIFO needs.
  always_comb begin
    pop      = out_valid_q && bus.out_ready;
    push_ok  = final_beat && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop);
    drop     = final_beat && (cnt_q == CNT_W'(FIFO_DEPTH)) && !pop;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = result;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
    out_valid_d = (cnt_d != '0);
    out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : '0;
    busy_d      = (round_cnt_d != '0) || (cnt_d != '0);
    ovf_d       = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt_q <= '0;
      rounds_q    <= RND_W'(1);
      shift_q     <= '0;
      relu_q      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      round_cnt_q <= round_cnt_d;
      rounds_q    <= rounds_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign round_cnt     = round_cnt_q;
  assign busy          = busy_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed self-checking bench for psum_accum: accumulation, rounding, saturation, FIFO and reset.
module tb_psum_accum import psum_pkg::*; ;

  logic               clk;
  logic               rst;
  logic [RND_W-1:0]   cfg_rounds;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_relu;
  logic [RND_W-1:0]   round_cnt;
  logic               busy;
  logic               ovf_err;

  int passes = 0;
  int total  = 0;

  psum_bus_t p;
  out_bus_t  e;

  psum_accum_if bus_if ();

  psum_accum u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_rounds (cfg_rounds),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .bus        (bus_if),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [OUT_BUS_W-1:0] obs,
                       input logic [OUT_BUS_W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic psum_bus_t pfill(input logic [PSUM_W-1:0] v);
    psum_bus_t r;
    for (int i = 0; i < NUM_LANES; i++) r[i*PSUM_W +: PSUM_W] = v;
    return r;
  endfunction

  function automatic out_bus_t ofill(input logic [OUT_W-1:0] v);
    out_bus_t r;
    for (int i = 0; i < NUM_LANES; i++) r[i*OUT_W +: OUT_W] = v;
    return r;
  endfunction

  task automatic beat(input psum_bus_t v);
    bus_if.Psum       = v;
    bus_if.Psum_valid = 1'b1;
    @(negedge clk);
    bus_if.Psum_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_rounds = 4'd1;
    cfg_shift  = 5'd0;
    cfg_relu   = 1'b0;
    bus_if.Psum_valid = 1'b0;
    bus_if.Psum       = '0;
    bus_if.out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", bus_if.out_valid, 1'b0);
    check("rst_data", bus_if.out_data, '0);
    check("rst_rcnt", round_cnt, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat group
    beat(pfill(24'd5));
    check("single_valid", bus_if.out_valid, 1'b1);
    check("single_data", bus_if.out_data, ofill(8'sd5));
    check("single_rcnt", round_cnt, 4'd0);
    check("single_busy", busy, 1'b1);
    pop_one();
    check("single_pop_valid", bus_if.out_valid, 1'b0);
    check("single_pop_data", bus_if.out_data, '0);
    check("single_pop_busy", busy, 1'b0);

    // Three rounds with gaps, rounding shift of 2, mid-group config changes ignored
    cfg_rounds = 4'd3;
    cfg_shift  = 5'd2;
    p = '0; p[23:0] = 24'd100;
    beat(p);
    check("multi_rcnt1", round_cnt, 4'd1);
    check("multi_busy1", busy, 1'b1);
    cfg_rounds = 4'd1;
    cfg_shift  = 5'd0;
    @(negedge clk);
    p = '0; p[23:0] = 24'd200;
    beat(p);
    check("multi_rcnt2", round_cnt, 4'd2);
    check("multi_valid2", bus_if.out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    p = '0; p[23:0] = 24'hFFFFCE;
    beat(p);
    e = '0; e[7:0] = 8'd63;
    check("multi_rcnt3", round_cnt, 4'd0);
    check("multi_valid3", bus_if.out_valid, 1'b1);
    check("multi_data", bus_if.out_data, e);
    pop_one();

    // Saturation, then ReLU
    cfg_rounds = 4'd1;
    cfg_shift  = 5'd0;
    cfg_relu   = 1'b0;
    p = '0; p[23:0] = 24'h7FFFFF; p[47:24] = 24'hFFFC18;
    beat(p);
    e = '0; e[7:0] = 8'h7F; e[15:8] = 8'h80;
    check("sat_data", bus_if.out_data, e);
    pop_one();
    cfg_relu = 1'b1;
    beat(p);
    e = '0; e[7:0] = 8'h7F; e[15:8] = 8'h00;
    check("relu_data", bus_if.out_data, e);
    pop_one();
    cfg_relu = 1'b0;

    // Backpressure and overflow drop
    beat(pfill(24'd1));
    beat(pfill(24'd2));
    check("bp_ovf_before", ovf_err, 1'b0);
    beat(pfill(24'd3));
    check("bp_ovf", ovf_err, 1'b1);
    check("bp_head1", bus_if.out_data, ofill(8'd1));
    @(negedge clk);
    check("bp_hold", bus_if.out_data, ofill(8'd1));
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp_head2", bus_if.out_data, ofill(8'd2));
    check("bp_valid2", bus_if.out_valid, 1'b1);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("bp_empty", bus_if.out_valid, 1'b0);
    check("bp_ovf_sticky", ovf_err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("bp_ovf_cleared", ovf_err, 1'b0);

    // Full FIFO with simultaneous push and pop
    beat(pfill(24'd4));
    beat(pfill(24'd5));
    bus_if.out_ready = 1'b1;
    beat(pfill(24'd6));
    check("full_pp_ovf", ovf_err, 1'b0);
    check("full_pp_head5", bus_if.out_data, ofill(8'd5));
    @(negedge clk);
    check("full_pp_head6", bus_if.out_data, ofill(8'd6));
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("full_pp_empty", bus_if.out_valid, 1'b0);
    check("full_pp_ovf_end", ovf_err, 1'b0);

    // Reset mid-group discards partial sums
    cfg_rounds = 4'd3;
    beat(pfill(24'd10));
    beat(pfill(24'd10));
    check("midrst_rcnt_pre", round_cnt, 4'd2);
    rst = 1'b1;
    #1;
    check("midrst_rcnt_async", round_cnt, 4'd0);
    check("midrst_busy_async", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    beat(pfill(24'd1));
    beat(pfill(24'd1));
    beat(pfill(24'd1));
    check("midrst_data", bus_if.out_data, ofill(8'd3));
    check("midrst_rcnt", round_cnt, 4'd0);
    pop_one();

    // cfg_rounds = 0 behaves as 1, back-to-back groups
    cfg_rounds = 4'd0;
    bus_if.out_ready = 1'b1;
    beat(pfill(24'd7));
    check("r0_data7", bus_if.out_data, ofill(8'd7));
    check("r0_rcnt", round_cnt, 4'd0);
    beat(pfill(24'd8));
    check("r0_data8", bus_if.out_data, ofill(8'd8));
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("r0_empty", bus_if.out_valid, 1'b0);
    check("r0_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
